// File: rtl/data_mem_hs_if.sv
// Request/response bundle for the byte-addressed data memory.
// Master issues requests under valid/ready; responses are a one-cycle strobe.
interface data_mem_hs_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [2:0]  req_u_b_h_w;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_u_b_h_w,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_u_b_h_w,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/data_mem_hs.sv
// Byte-addressed data memory with byte/half/word access, range and alignment faults.
// Response strobes LATENCY edges after accept; one request in flight, no response backpressure.
module data_mem_hs #(
  parameter int ADDR_BITS = 7,
  parameter int LATENCY   = 2
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_hs_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  fault_q, fault_d;
  logic [7:0]  mem_q [DEPTH];

  logic        accept, enter_resp, mem_we;
  logic [31:0] op_addr, op_wdata, load_data;
  logic        op_we, is_word, is_half;
  logic [2:0]  op_size;
  logic [ADDR_BITS-1:0] idx0, idx1, idx2, idx3;
  logic [7:0]  b0, b1, b2, b3;

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  // With LATENCY=1 the commit edge is the accept edge, so use the live bus in IDLE.
  assign op_addr  = (state_q == IDLE) ? bus.req_addr    : addr_q;
  assign op_wdata = (state_q == IDLE) ? bus.req_wdata   : wdata_q;
  assign op_we    = (state_q == IDLE) ? bus.req_we      : we_q;
  assign op_size  = (state_q == IDLE) ? bus.req_u_b_h_w : size_q;

  assign is_word = op_size[1];
  assign is_half = !op_size[1] && op_size[0];

  assign fault_d[0] = (op_addr >> ADDR_BITS) != 32'd0;
  assign fault_d[1] = (is_half && op_addr[0]) || (is_word && (op_addr[1:0] != 2'b00));

  assign idx0 = op_addr[ADDR_BITS-1:0];
  assign idx1 = idx0 + ADDR_BITS'(1);
  assign idx2 = idx0 + ADDR_BITS'(2);
  assign idx3 = idx0 + ADDR_BITS'(3);
  assign b0   = mem_q[idx0];
  assign b1   = mem_q[idx1];
  assign b2   = mem_q[idx2];
  assign b3   = mem_q[idx3];

  always_comb begin
    load_data = {b3, b2, b1, b0};
    if (is_half) begin
      load_data = op_size[2] ? {16'h0000, b1, b0} : {{16{b1[7]}}, b1, b0};
    end else if (!is_word) begin
      load_data = op_size[2] ? {24'h000000, b0} : {{24{b0[7]}}, b0};
    end
    rdata_d = ((fault_d != 2'b00) || op_we) ? 32'd0 : load_data;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_we = enter_resp && !rst && op_we && (fault_d == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      fault_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= enter_resp ? rdata_d : 32'd0;
      fault_q <= enter_resp ? fault_d : 2'b00;
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        we_q    <= bus.req_we;
        size_q  <= bus.req_u_b_h_w;
      end
    end
  end

  // Storage survives reset; only an abandoned store is suppressed.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx0] <= op_wdata[7:0];
      if (is_half || is_word) mem_q[idx1] <= op_wdata[15:8];
      if (is_word) begin
        mem_q[idx2] <= op_wdata[23:16];
        mem_q[idx3] <= op_wdata[31:24];
      end
    end
  end

  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;
endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs: directed vector table, reset-abort and back-to-back sequences,
// and random traffic against a byte-array reference model.
module tb_data_mem_hs;
  localparam int AB  = 7;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_hs_if bus ();
  data_mem_hs_if bus2 ();

  data_mem_hs #(.ADDR_BITS(AB), .LATENCY(LAT)) dut  (.clk(clk), .rst(rst), .bus(bus));
  data_mem_hs #(.ADDR_BITS(AB), .LATENCY(1))   dut1 (.clk(clk), .rst(rst), .bus(bus2));

  int errors = 0;
  int checks = 0;
  logic [7:0] ref_mem [2**AB];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ubhw;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_fault;
  } vec_t;
  vec_t vecs [18];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: size in bytes, fault rules and sign extension computed arithmetically.
  task automatic model_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] ubhw, output logic [31:0] rdata, output logic [1:0] fault);
    int n;
    logic [31:0] v;
    n = ubhw[1] ? 4 : (ubhw[0] ? 2 : 1);
    fault[0] = addr >= 32'(2**AB);
    fault[1] = (addr % n) != 0;
    rdata = 32'd0;
    if (fault == 2'b00) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr + i]) << (8*i));
        if (!ubhw[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
        rdata = v;
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] ubhw, output logic [31:0] rdata, output logic [1:0] fault);
    int k;
    check("ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    bus.req_u_b_h_w = ubhw;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    k = 0;
    while (!bus.resp_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("resp_latency", 32'(k), 32'(LAT));
    rdata = bus.resp_rdata;
    fault = bus.resp_fault;
    @(posedge clk); #1;
    check("resp_one_cycle", {31'd0, bus.resp_valid}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] ar, er, pat;
    logic [1:0]  af, ef;
    logic [31:0] a;
    logic        w;
    logic [2:0]  s;

    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h00000000, 2'b00};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 2'b00};
    vecs[2]  = '{1'b0, 32'h13,  32'h0,        3'b000, 32'hFFFFFFDE, 2'b00};
    vecs[3]  = '{1'b0, 32'h13,  32'h0,        3'b100, 32'h000000DE, 2'b00};
    vecs[4]  = '{1'b0, 32'h12,  32'h0,        3'b001, 32'hFFFFDEAD, 2'b00};
    vecs[5]  = '{1'b1, 32'h11,  32'h1234,     3'b001, 32'h00000000, 2'b10};
    vecs[6]  = '{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 2'b00};
    vecs[7]  = '{1'b0, 32'h80,  32'h0,        3'b010, 32'h00000000, 2'b01};
    vecs[8]  = '{1'b0, 32'h81,  32'h0,        3'b010, 32'h00000000, 2'b11};
    vecs[9]  = '{1'b0, 32'h10,  32'h0,        3'b101, 32'h0000BEEF, 2'b00};
    vecs[10] = '{1'b0, 32'h11,  32'h0,        3'b000, 32'hFFFFFFBE, 2'b00};
    vecs[11] = '{1'b1, 32'h7F,  32'h123456AA, 3'b000, 32'h00000000, 2'b00};
    vecs[12] = '{1'b0, 32'h7F,  32'h0,        3'b000, 32'hFFFFFFAA, 2'b00};
    vecs[13] = '{1'b0, 32'h7F,  32'h0,        3'b001, 32'h00000000, 2'b10};
    vecs[14] = '{1'b1, 32'h100, 32'h0,        3'b010, 32'h00000000, 2'b01};
    vecs[15] = '{1'b0, 32'h10,  32'h0,        3'b110, 32'hDEADBEEF, 2'b00};
    vecs[16] = '{1'b0, 32'h12,  32'h0,        3'b101, 32'h0000DEAD, 2'b00};
    vecs[17] = '{1'b0, 32'h12,  32'h0,        3'b011, 32'h00000000, 2'b10};

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_u_b_h_w = '0;
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0;
    bus2.req_wdata = '0;   bus2.req_u_b_h_w = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  {31'd0, bus.req_ready},  32'd0);
    check("rst_valid",  {31'd0, bus.resp_valid}, 32'd0);
    check("rst_rdata",  bus.resp_rdata,          32'd0);
    check("rst_fault",  {30'd0, bus.resp_fault}, 32'd0);
    check("rst_ready1", {31'd0, bus2.req_ready}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

    for (int wi = 0; wi < 2**AB / 4; wi++) begin
      pat = (wi == 8) ? 32'h11223344 : $urandom;
      model_req(1'b1, 32'(wi * 4), pat, 3'b010, er, ef);
      do_req(1'b1, 32'(wi * 4), pat, 3'b010, ar, af);
    end

    for (int i = 0; i < 18; i++) begin
      model_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ubhw, er, ef);
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ubhw, ar, af);
      check($sformatf("vec%0d_rdata", i), ar, vecs[i].exp_rdata);
      check($sformatf("vec%0d_fault", i), {30'd0, af}, {30'd0, vecs[i].exp_fault});
    end

    // Store abandoned by reset one edge after accept.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h20;
    bus.req_wdata = 32'h55; bus.req_u_b_h_w = 3'b000;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ready_in_rst", {31'd0, bus.req_ready}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("abort_no_resp", {31'd0, bus.resp_valid}, 32'd0);
      if (c == 0) check("abort_ready_after", {31'd0, bus.req_ready}, 32'd1);
    end
    model_req(1'b0, 32'h20, 32'h0, 3'b100, er, ef);
    do_req(1'b0, 32'h20, 32'h0, 3'b100, ar, af);
    check("abort_byte_kept", ar, er);

    for (int r = 0; r < 150; r++) begin
      a = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(7, 31));
      w = 1'($urandom_range(0, 1));
      s = 3'($urandom_range(0, 7));
      pat = $urandom;
      model_req(w, a, pat, s, er, ef);
      do_req(w, a, pat, s, ar, af);
      check($sformatf("rand%0d_rdata a=%0h s=%0d we=%0d", r, a, s, w), ar, er);
      check($sformatf("rand%0d_fault a=%0h s=%0d we=%0d", r, a, s, w), {30'd0, af}, {30'd0, ef});
    end

    // LATENCY=1 with valid held high: accept on every other edge.
    bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_addr = 32'h4;
    bus2.req_wdata = 32'hCAFEF00D; bus2.req_u_b_h_w = 3'b010;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("l1_ready%0d", i), {31'd0, bus2.req_ready},  32'(i % 2 == 0));
      check($sformatf("l1_valid%0d", i), {31'd0, bus2.resp_valid}, 32'(i % 2 == 1));
      if (i == 1) begin
        check("l1_store_rdata", bus2.resp_rdata, 32'd0);
        bus2.req_we = 1'b0;
      end
      if (i == 3) check("l1_load_rdata", bus2.resp_rdata, 32'hCAFEF00D);
      @(posedge clk); #1;
    end
    bus2.req_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_hs.md
DATA_MEM_HS -- requirements
Module: data_mem_hs

Interface
REQ-001 Parameter ADDR_BITS, default 7, SHALL set the byte-address width; storage SHALL be 2**ADDR_BITS bytes.
REQ-002 Parameter LATENCY, default 2, SHALL set the cycles from request accept to response; legal range 1..15.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_we  input  1  1=store, 0=load.
REQ-009 req_wdata  input  32  store data, little-endian, LSB-aligned.
REQ-010 req_u_b_h_w  input  3  bit1 word, else bit0 half, else byte; bit2 unsigned load.
REQ-011 resp_valid  output  1  one-cycle response strobe.
REQ-012 resp_rdata  output  32  formatted load data.
REQ-013 resp_fault  output  2  bit0 out-of-range, bit1 misaligned.

Function
REQ-014 FSM states SHALL be IDLE, BUSY, RESP; req_ready SHALL be 1 only in IDLE with rst low.
REQ-015 Accept SHALL occur on a posedge with req_valid & req_ready; addr, we, wdata, size SHALL be captured, and the state SHALL go to BUSY (LATENCY>1) or RESP (LATENCY=1).
REQ-016 BUSY SHALL count down a 4-bit counter loaded with LATENCY-1; at zero the state SHALL go to RESP, so resp_valid rises exactly LATENCY edges after the accept edge.
REQ-017 RESP SHALL last exactly one cycle with resp_valid=1, then IDLE; there is no response backpressure.
REQ-018 Throughput SHALL be one request per LATENCY+1 cycles; req_valid outside IDLE SHALL be ignored.
REQ-019 Out-of-range: any nonzero bit in captured addr[31:ADDR_BITS] SHALL set fault bit0.
REQ-020 Misaligned: half with addr[0]=1, or word with addr[1:0]!=0, SHALL set fault bit1; both bits may be set together.
REQ-021 A faulting request SHALL not modify storage and SHALL return resp_rdata=0.
REQ-022 A non-faulting store SHALL write 1/2/4 bytes (byte/half/word) little-endian at addr on the edge entering RESP; resp_rdata SHALL be 0 for stores.
REQ-023 A non-faulting load SHALL register data on the edge entering RESP: word as-is; half and byte sign-extended from their MSB unless bit2=1, then zero-extended.
REQ-024 Outside RESP, resp_rdata and resp_fault SHALL be 0.
REQ-025 Addresses within range SHALL not wrap; alignment rules make multi-byte wrap impossible.

Reset
REQ-026 On a posedge with rst=1: state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_fault 0; req_ready SHALL be 0 while rst is high and 1 the cycle after.
REQ-027 Reset mid-operation SHALL abandon the pending request: no storage write, no response.
REQ-028 Storage contents SHALL not be cleared by reset.

Verification
REQ-029 LATENCY=2: store word 0xDEADBEEF at 0x10, then load word at 0x10 -> resp_valid two edges after each accept, rdata 0xDEADBEEF, fault 0.
REQ-030 After REQ-029: load byte 0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load half 0x12 signed -> 0xFFFFDEAD.
REQ-031 Store half at 0x11 -> fault 2'b10, rdata 0, word at 0x10 still 0xDEADBEEF.
REQ-032 ADDR_BITS=7: load word at 0x80 -> fault 2'b01, rdata 0; word at 0x81 -> fault 2'b11.
REQ-033 Store byte 0x55 to 0x20, assert rst one edge after accept -> no resp_valid, byte 0x20 unchanged, req_ready 1 the cycle after rst drops.
REQ-034 LATENCY=1, req_valid held high -> accepts every 2nd cycle, resp_valid alternates 0/1, req_ready 0 in RESP.
